// File: rtl/ysyx_22050499_lsu_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states, AXI response codes.
package ysyx_22050499_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    HOLD
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_22050499_lsu_if.sv
// AXI4-lite channel bundle between the load/store stage (master) and memory (slave).
interface ysyx_22050499_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              wvalid, wready;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              rvalid, rready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arsize, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arsize, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_22050499_lsu_align.sv
// Byte-lane alignment: store data/strobe shifting and load shift plus sign/zero extension.
module ysyx_22050499_lsu_align
  import ysyx_22050499_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [1:0]                size,
  input  logic                      unsgn,
  input  logic [XLEN-1:0]           st_data,
  input  logic [XLEN-1:0]           ld_raw,
  output logic [XLEN-1:0]           st_data_sh,
  output logic [XLEN/8-1:0]         st_strb,
  output logic [XLEN-1:0]           ld_data
);
  localparam int STRB_W = XLEN / 8;

  logic [STRB_W-1:0] strb_base;
  logic [XLEN-1:0]   ld_sh;

  assign st_data_sh = st_data << {lane, 3'b000};

  always_comb begin
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (i < int'(size_bytes(size))) strb_base[i] = 1'b1;
    end
  end

  // Bytes shifted past the top lane are dropped: wide accesses truncate at the bus width.
  assign st_strb = strb_base << lane;
  assign ld_sh   = ld_raw >> {lane, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (size)
      SZ_B: ld_data = unsgn ? XLEN'(ld_sh[7:0])  : XLEN'($signed(ld_sh[7:0]));
      SZ_H: ld_data = unsgn ? XLEN'(ld_sh[15:0]) : XLEN'($signed(ld_sh[15:0]));
      SZ_W: ld_data = unsgn ? XLEN'(ld_sh[31:0]) : XLEN'($signed(ld_sh[31:0]));
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050499_lsu.sv
// Single-entry load/store stage between EX and WB driving AXI4-lite directly.
// Optional misaligned-access trap: define YSYX_22050499_LSU_MISALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | empty, ready for a new op
// WR_REQ  | AW and W offered, each drops on its own handshake
// WR_RESP | waiting for B
// RD_REQ  | AR offered
// RD_RESP | waiting for R
// HOLD    | result presented to WB
module ysyx_22050499_lsu
  import ysyx_22050499_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int PASS_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_we,
  input  logic              in_re,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [PASS_W-1:0] in_side,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [XLEN-1:0]   out_rdata,
  output logic [PASS_W-1:0] out_side,
  output logic              out_err,
  ysyx_22050499_lsu_if.master axi
);
  localparam int LANE_W = $clog2(XLEN / 8);

  lsu_state_t        state;
  logic              kill;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [PASS_W-1:0] side_q;

  logic              accept, in_mis, aw_done, w_done;
  logic [1:0]        in_size_eff;
  logic [XLEN-1:0]   st_data, ld_data;
  logic [XLEN/8-1:0] st_strb;

  assign in_ready    = !reset && (state == IDLE || (state == HOLD && out_ready));
  assign accept      = in_valid && in_ready;
  assign in_size_eff = (XLEN == 32 && in_size == SZ_D) ? SZ_W : in_size;

`ifdef YSYX_22050499_LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (in_size)
      SZ_B:    in_mis = 1'b0;
      SZ_H:    in_mis = in_addr[0];
      SZ_W:    in_mis = |in_addr[1:0];
      default: in_mis = (XLEN == 32) || (|in_addr[2:0]);
    endcase
  end
`else
  assign in_mis = 1'b0;
`endif

  ysyx_22050499_lsu_align #(.XLEN(XLEN)) u_align (
    .lane       (addr_q[LANE_W-1:0]),
    .size       (size_q),
    .unsgn      (uns_q),
    .st_data    (wdata_q),
    .ld_raw     (axi.rdata),
    .st_data_sh (st_data),
    .st_strb    (st_strb),
    .ld_data    (ld_data)
  );

  assign axi.awaddr = addr_q;
  assign axi.araddr = addr_q;
  assign axi.awsize = {1'b0, size_q};
  assign axi.arsize = {1'b0, size_q};
  assign axi.wdata  = st_data;
  assign axi.wstrb  = axi.wvalid ? st_strb : '0;

  assign out_pc    = pc_q;
  assign out_rdata = rdata_q;
  assign out_side  = side_q;

  assign aw_done = !axi.awvalid || axi.awready;
  assign w_done  = !axi.wvalid || axi.wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      kill        <= 1'b0;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      pc_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      side_q      <= '0;
    end else begin
      case (state)
        WR_REQ: begin
          if (in_flush) kill <= 1'b1;
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready) axi.wvalid <= 1'b0;
          if (aw_done && w_done) begin
            state      <= WR_RESP;
            axi.bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (in_flush) kill <= 1'b1;
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            if (kill || in_flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_err   <= (axi.bresp != RESP_OKAY);
            end
          end
        end
        RD_REQ: begin
          if (in_flush) kill <= 1'b1;
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (in_flush) kill <= 1'b1;
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            if (kill || in_flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_err   <= (axi.rresp != RESP_OKAY);
              rdata_q   <= ld_data;
            end
          end
        end
        HOLD: begin
          // A flush retires the held result as if WB had never seen it.
          if (in_flush || out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept && !in_flush) begin
        pc_q      <= in_pc;
        addr_q    <= in_addr;
        wdata_q   <= in_wdata;
        size_q    <= in_size_eff;
        uns_q     <= in_unsigned;
        side_q    <= in_side;
        rdata_q   <= '0;
        out_err   <= 1'b0;
        out_valid <= 1'b0;
        kill      <= 1'b0;
        if ((in_we || in_re) && in_mis) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_err   <= 1'b1;
        end else if (in_we) begin
          state       <= WR_REQ;
          axi.awvalid <= 1'b1;
          axi.wvalid  <= 1'b1;
        end else if (in_re) begin
          state       <= RD_REQ;
          axi.arvalid <= 1'b1;
        end else begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050499_lsu.sv
// Self-checking bench for ysyx_22050499_lsu (XLEN=32) with a delay-configurable AXI slave.
module tb_ysyx_22050499_lsu;
  import ysyx_22050499_lsu_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, PASS_W = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              in_valid, in_ready, in_we, in_re, in_unsigned, in_flush;
  logic              out_valid, out_ready, out_err;
  logic [31:0]       in_pc, out_pc;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_wdata, out_rdata;
  logic [1:0]        in_size;
  logic [PASS_W-1:0] in_side, out_side;

  ysyx_22050499_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) axi ();

  ysyx_22050499_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_we(in_we), .in_re(in_re), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_side(in_side), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rdata(out_rdata), .out_side(out_side), .out_err(out_err),
    .axi(axi)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [XLEN-1:0]   rdata;
    logic              err;
    logic [PASS_W-1:0] side;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, pops = 0;

  // ---------------- AXI slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0, b_hs = 0, ar_cyc = 0;
  bit aw_done = 0, w_done = 0, r_pend = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awsize, cap_arsize;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);
  assign axi.arready = axi.arvalid && (ar_cnt >= ar_delay);
  assign axi.bvalid  = aw_done && w_done && (b_cnt >= b_delay);
  assign axi.rvalid  = r_pend && (r_cnt >= r_delay);
  assign axi.bresp   = b_resp_cfg;
  assign axi.rresp   = r_resp_cfg;
  assign axi.rdata   = r_data_cfg;

  always @(posedge clock) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      aw_done <= 0; w_done <= 0; r_pend <= 0;
    end else begin
      if (axi.arvalid) ar_cyc <= ar_cyc + 1;
      if (axi.awvalid && axi.awready) begin
        aw_done <= 1; aw_cnt <= 0; aw_hs <= aw_hs + 1;
        cap_awaddr <= axi.awaddr; cap_awsize <= axi.awsize;
      end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
      if (axi.wvalid && axi.wready) begin
        w_done <= 1; w_cnt <= 0; w_hs <= w_hs + 1;
        cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb;
      end else if (axi.wvalid) w_cnt <= w_cnt + 1;
      if (aw_done && w_done) begin
        if (axi.bvalid && axi.bready) begin
          aw_done <= 0; w_done <= 0; b_cnt <= 0; b_hs <= b_hs + 1;
        end else b_cnt <= b_cnt + 1;
      end
      if (axi.arvalid && axi.arready) begin
        r_pend <= 1; r_cnt <= 0; ar_cnt <= 0; ar_hs <= ar_hs + 1;
        cap_araddr <= axi.araddr; cap_arsize <= axi.arsize;
      end else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
      if (r_pend) begin
        if (axi.rvalid && axi.rready) begin
          r_pend <= 0; r_cnt <= 0; r_hs <= r_hs + 1;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got result pc=%h, required no result", out_pc);
      end else begin
        mon_e = sb.pop_front();
        pops++;
        if (out_pc !== mon_e.pc || out_rdata !== mon_e.rdata ||
            out_err !== mon_e.err || out_side !== mon_e.side) begin
          errors++;
          $display("FAIL sb_result: got pc=%h rdata=%h err=%b side=%h, required pc=%h rdata=%h err=%b side=%h",
                   out_pc, out_rdata, out_err, out_side, mon_e.pc, mon_e.rdata, mon_e.err, mon_e.side);
        end
      end
    end
  end

  // Presents one op and returns just after the posedge that accepts it.
  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic re, input logic [1:0] sz, input logic uns,
                       input logic [31:0] erd, input logic eerr, input bit push);
    int n;
    exp_t e;
    @(negedge clock);
    in_pc = pc; in_addr = addr; in_wdata = wd; in_we = we; in_re = re;
    in_size = sz; in_unsigned = uns; in_side = {pc, ~pc}; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    if (push) begin
      e.pc = pc; e.rdata = erd; e.err = eerr; e.side = {pc, ~pc};
      sb.push_back(e);
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++;
    if ({out_valid, out_err} !== 2'b00) begin
      errors++; $display("FAIL reset_out: out_valid/out_err=%b, required 00", {out_valid, out_err});
    end
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi: aw/w/ar/b/r=%b, required 00000",
               {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_load_sb();
    int lat;
    r_data_cfg = 32'h80FF_1234;
    issue(32'h1000, 32'h8000_0003, 32'h0, 1'b0, 1'b1, SZ_B, 1'b0, 32'hFFFF_FF80, 1'b0, 1);
    @(negedge clock); in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clock); lat++; end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL load_sb_latency: got %0d cycles, required 3", lat); end
    checks++;
    if (cap_araddr !== 32'h8000_0003 || cap_arsize !== 3'd0) begin
      errors++; $display("FAIL load_sb_ar: araddr=%h arsize=%0d, required 80000003 0", cap_araddr, cap_arsize);
    end
    @(negedge clock);
  endtask

  typedef struct { logic [31:0] addr; logic [1:0] sz; logic uns; logic [31:0] rd; logic [31:0] exp; } ld_vec_t;

  task automatic test_load_ext();
    ld_vec_t v[4];
    int n;
    v[0] = '{32'h8000_0002, SZ_H, 1'b0, 32'h8001_0000, 32'hFFFF_8001};
    v[1] = '{32'h8000_0002, SZ_H, 1'b1, 32'h8001_0000, 32'h0000_8001};
    v[2] = '{32'h8000_0001, SZ_B, 1'b1, 32'h0000_A500, 32'h0000_00A5};
    v[3] = '{32'h8000_0000, SZ_W, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      r_data_cfg = v[i].rd;
      issue(32'h2000 + 32'(i * 4), v[i].addr, 32'h0, 1'b0, 1'b1, v[i].sz, v[i].uns, v[i].exp, 1'b0, 1);
      @(negedge clock); in_valid = 1'b0; n = 0;
      while (!out_valid && n < 20) begin @(negedge clock); n++; end
      if (!out_valid) begin checks++; errors++; $display("FAIL load_ext_timeout: out_valid=0, required 1"); end
      @(negedge clock);
    end
  endtask

  task automatic test_store_sh();
    int n, aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    aw_delay = 3; w_delay = 0;
    issue(32'h3000, 32'h8000_0002, 32'h0000_BEEF, 1'b1, 1'b0, SZ_H, 1'b0, 32'h0, 1'b0, 1);
    @(negedge clock); in_valid = 1'b0; n = 0;
    while (!out_valid && n < 30) begin @(negedge clock); n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL store_timeout: out_valid=%b, required 1", out_valid); end
    checks++;
    if (cap_wdata !== 32'hBEEF_0000 || cap_wstrb !== 4'b1100) begin
      errors++; $display("FAIL store_w: wdata=%h wstrb=%b, required beef0000 1100", cap_wdata, cap_wstrb);
    end
    checks++;
    if (cap_awaddr !== 32'h8000_0002 || cap_awsize !== 3'd1) begin
      errors++; $display("FAIL store_aw: awaddr=%h awsize=%0d, required 80000002 1", cap_awaddr, cap_awsize);
    end
    checks++;
    if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
      errors++; $display("FAIL store_hs: aw/w/b handshakes=%0d/%0d/%0d, required 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    aw_delay = 0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    int p0, ar0, aw0;
    p0 = pops; ar0 = ar_cyc; aw0 = aw_hs;
    out_ready = 1'b1;
    issue(32'h4000, 32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 1'b0, 1);
    t0 = $time;
    for (int i = 1; i < 4; i++)
      issue(32'h4000 + 32'(i * 4), 32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 1'b0, 1);
    t1 = $time;
    @(negedge clock); in_valid = 1'b0;
    #2;
    checks++;
    if (t1 - t0 != 30) begin errors++; $display("FAIL b2b_rate: 4 accepts took %0t, required 30", t1 - t0); end
    checks++;
    if (pops - p0 != 4) begin errors++; $display("FAIL b2b_results: got %0d results, required 4", pops - p0); end
    checks++;
    if (ar_cyc != ar0 || aw_hs != aw0) begin errors++; $display("FAIL b2b_axi: bus activity seen, required none"); end
    @(negedge clock);
  endtask

  task automatic test_flush_rd();
    int n, r0, p0;
    bit rr_ok;
    r0 = r_hs; r_delay = 5; rr_ok = 1;
    issue(32'h5000, 32'h8000_0020, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clock); in_valid = 1'b0; n = 0;
    while (!axi.rready && n < 20) begin @(negedge clock); n++; end
    in_flush = 1'b1;
    @(negedge clock); in_flush = 1'b0; n = 0;
    while (r_hs == r0 && n < 30) begin
      if (!axi.rready) rr_ok = 0;
      @(negedge clock); n++;
    end
    checks++;
    if (r_hs - r0 != 1 || !rr_ok) begin
      errors++; $display("FAIL flush_rd_bus: r handshakes=%0d rready_held=%0d, required 1 1", r_hs - r0, rr_ok);
    end
    repeat (3) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_out: out_valid=%b, required 0", out_valid); end
      @(negedge clock);
    end
    r_delay = 0; p0 = pops;
    issue(32'h5004, 32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 1'b0, 1);
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL flush_rd_next: got %0d results, required 1", pops - p0); end
  endtask

  task automatic test_rresp_err();
    int n;
    r_resp_cfg = RESP_SLVERR; r_data_cfg = 32'hCAFE_F00D; out_ready = 1'b0;
    issue(32'h6000, 32'h8000_0010, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b1, 1);
    @(negedge clock); in_valid = 1'b0; n = 0;
    while (!out_valid && n < 20) begin @(negedge clock); n++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h6000 || out_err !== 1'b1) begin
        errors++;
        $display("FAIL rresp_hold: valid=%b pc=%h err=%b, required 1 00006000 1", out_valid, out_pc, out_err);
      end
      @(negedge clock);
    end
    out_ready = 1'b1; r_resp_cfg = RESP_OKAY;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_flush_hold();
    int ar0;
    in_flush = 1'b1;
    @(negedge clock); in_flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    issue(32'h7000, 32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clock); in_valid = 1'b0; in_flush = 1'b1;
    @(negedge clock); in_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold: out_valid=%b, required 0", out_valid); end
    out_ready = 1'b1; ar0 = ar_cyc;
    in_flush = 1'b1;
    issue(32'h7004, 32'h8000_0040, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clock); in_valid = 1'b0; in_flush = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ar_cyc != ar0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_accept: arvalid cycles=%0d out_valid=%b, required 0 0", ar_cyc - ar0, out_valid);
    end
  endtask

  task automatic test_misalign();
    int lat, ar0, hs0;
    r_data_cfg = 32'h1122_3344; ar0 = ar_cyc; hs0 = ar_hs;
`ifdef YSYX_22050499_LSU_MISALIGN_CHECK_EN
    issue(32'h8000, 32'h8000_0001, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0, 32'h0, 1'b1, 1);
    @(negedge clock); in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clock); lat++; end
    checks++;
    if (lat !== 1 || ar_cyc != ar0) begin
      errors++; $display("FAIL misalign_trap: latency=%0d arvalid cycles=%0d, required 1 0", lat, ar_cyc - ar0);
    end
`else
    issue(32'h8000, 32'h8000_0001, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0, 32'h0011_2233, 1'b0, 1);
    @(negedge clock); in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clock); lat++; end
    checks++;
    if (ar_hs - hs0 != 1 || cap_araddr !== 32'h8000_0001) begin
      errors++; $display("FAIL misalign_issue: ar handshakes=%0d araddr=%h, required 1 80000001", ar_hs - hs0, cap_araddr);
    end
`endif
    @(negedge clock);
  endtask

  initial begin
    in_valid = 0; in_we = 0; in_re = 0; in_unsigned = 0; in_flush = 0; out_ready = 1;
    in_pc = 0; in_addr = 0; in_wdata = 0; in_size = 0; in_side = 0;
    test_reset();
    test_load_sb();
    test_load_ext();
    test_store_sh();
    test_back_to_back();
    test_flush_rd();
    test_rresp_err();
    test_flush_hold();
    test_misalign();
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
